// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, memory widths,
// requester indices and memory function codes.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;

  localparam int REQ_MTU = 0;
  localparam int REQ_NEM = 1;
  localparam int REQ_GC  = 2;

  localparam logic [1:0] FUNC_READ  = 2'd1;
  localparam logic [1:0] FUNC_WRITE = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: the first active request at or after ptr_i
// wins, returned both one-hot and as an index.
module mem_arbiter_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;

  // Scan farthest-first so the candidate closest to ptr_i is written last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of the single-port memory unit, with bounded lock
// bursts for read-modify-write sequences and a WAIT timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int LOCK_MAX = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_execute,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [2*NUM_REQ-1:0]      req_func,
  input  logic [ADDR_W*NUM_REQ-1:0] req_address,
  input  logic [DATA_W*NUM_REQ-1:0] req_write_data,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      timeout_err,
  output logic [1:0]                mem_func,
  output logic                      mem_execute,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data,
  input  logic                      mem_ready
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LCNT_W = $clog2(LOCK_MAX + 1);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, done_q, done_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d, rr_ptr_q, rr_ptr_d;
  logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                exec_q, exec_d, tmo_q, tmo_d;
  logic [1:0]          func_q, func_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rd_q, rd_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx, load_idx;
  logic                load;

  logic [1:0]          func_arr  [NUM_REQ];
  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign func_arr[i]  = req_func[2*i +: 2];
    assign addr_arr[i]  = req_address[ADDR_W*i +: ADDR_W];
    assign wdata_arr[i] = req_write_data[DATA_W*i +: DATA_W];
  end

  mem_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req_execute),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    wait_cnt_d = wait_cnt_q;
    exec_d     = exec_q;
    func_d     = func_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    done_d     = '0;
    tmo_d      = 1'b0;
    load       = 1'b0;
    load_idx   = pick_idx;

    unique case (state_q)
      ARB_IDLE: begin
        if (mem_ready && (|req_execute)) begin
          load    = 1'b1;
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          exec_d  = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (!mem_ready) begin
          exec_d     = 1'b0;
          wait_cnt_d = '0;
          state_d    = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (mem_ready) begin
          rd_d    = mem_read_data;
          done_d  = grant_q;
          state_d = ARB_DONE;
        end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          tmo_d      = 1'b1;
          grant_d    = '0;
          lock_cnt_d = '0;
          state_d    = ARB_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ARB_DONE: begin
        // Locked follow-on goes straight back to ISSUE; the cap forces a release.
        if (req_lock[gidx_q] && req_execute[gidx_q] &&
            (lock_cnt_q < LCNT_W'(LOCK_MAX - 1))) begin
          lock_cnt_d = lock_cnt_q + LCNT_W'(1);
          load       = 1'b1;
          load_idx   = gidx_q;
          exec_d     = 1'b1;
          state_d    = ARB_ISSUE;
        end else begin
          lock_cnt_d = '0;
          rr_ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
          grant_d    = '0;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (load) begin
      func_d  = func_arr[load_idx];
      addr_d  = addr_arr[load_idx];
      wdata_d = wdata_arr[load_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
      wait_cnt_q <= '0;
      exec_q     <= 1'b0;
      func_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      done_q     <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      exec_q     <= exec_d;
      func_q     <= func_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign req_grant      = grant_q;
  assign req_done       = done_q;
  assign rd_data        = rd_q;
  assign timeout_err    = tmo_q;
  assign mem_func       = func_q;
  assign mem_execute    = exec_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule
